// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU encodings, forwarding selects
// and the multiply sequencer state encoding.
package ex_stage_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_MUL = 6'h18;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] FWD_REG_ALT = 2'b11;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT,
    ALU_MUL
  } alu_op_e;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_state_e;

  // Unknown funct codes fall back to ADD so a bad encoding never wedges the stage.
  function automatic alu_op_e decode_alu(input logic [1:0] alu_op, input logic [5:0] funct);
    alu_op_e op;
    op = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_OR:  op = ALU_OR;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: op = ALU_ADD;
          FUNCT_SUB: op = ALU_SUB;
          FUNCT_AND: op = ALU_AND;
          FUNCT_OR:  op = ALU_OR;
          FUNCT_NOR: op = ALU_NOR;
          FUNCT_SLT: op = ALU_SLT;
          FUNCT_MUL: op = ALU_MUL;
          default:   op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Select 11 aliases the register value, same as 00.
  function automatic logic [31:0] fwd_select(input logic [1:0] sel, input logic [31:0] reg_val,
                                             input logic [31:0] mem_val, input logic [31:0] wb_val);
    logic [31:0] v;
    case (sel)
      FWD_MEM:     v = mem_val;
      FWD_WB:      v = wb_val;
      FWD_REG_ALT: v = reg_val;
      default:     v = reg_val;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, 32 cycles,
// keeping the low 32 bits of the product.
module ex_mul_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  mul_state_e  state_q, state_d;
  logic [4:0]  count_q;
  logic [31:0] mcand_q, mplier_q, product_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= MUL_IDLE;
    else     state_q <= state_d;
  end

  // Next state: flush abandons any operation; DONE always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = MUL_IDLE;
    end else begin
      case (state_q)
        MUL_IDLE: if (start) state_d = MUL_BUSY;
        MUL_BUSY: if (count_q == 5'd31) state_d = MUL_DONE;
        MUL_DONE: state_d = MUL_IDLE;
        default:  state_d = MUL_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (state_q == MUL_BUSY);
    done = (state_q == MUL_DONE);
  end

  // Operand latch and shift-add datapath; operands are captured only on start.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
    end else if (state_q == MUL_IDLE && start && !flush) begin
      count_q   <= '0;
      mcand_q   <= a;
      mplier_q  <= b;
      product_q <= '0;
    end else if (state_q == MUL_BUSY && !flush) begin
      if (mplier_q[0]) product_q <= product_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + 5'd1;
    end
  end

  assign product = product_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch target, iterative multiply
// and the EX/MEM pipeline register.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc_plus4,
  input  logic [31:0] i_read_data1,
  input  logic [31:0] i_read_data2,
  input  logic [31:0] i_sign_ext_imm,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [3:0]  i_EX_control,
  input  logic [2:0]  i_MEM_control,
  input  logic [1:0]  i_WB_control,
  input  logic [1:0]  i_fwd_a,
  input  logic [1:0]  i_fwd_b,
  input  logic [31:0] i_mem_fwd_data,
  input  logic [31:0] i_wb_fwd_data,
  input  logic        i_flush,
  output logic [31:0] o_branch_pc,
  output logic [31:0] o_result,
  output logic [31:0] o_read_data2,
  output logic        o_zero,
  output logic [4:0]  o_write_reg,
  output logic [1:0]  o_WB_control,
  output logic [2:0]  o_MEM_control,
  output logic        o_stall
);

  logic        reg_dst, alu_src;
  logic [1:0]  alu_op_code;
  alu_op_e     alu_op;
  logic [31:0] opnd_a, opnd_b, alu_b, alu_result, branch_pc;
  logic [4:0]  write_reg;
  logic        is_mul, mul_busy, mul_done;
  logic [31:0] mul_product;

  assign {reg_dst, alu_src, alu_op_code} = i_EX_control;
  assign alu_op    = decode_alu(alu_op_code, i_sign_ext_imm[5:0]);
  assign is_mul    = (alu_op == ALU_MUL);
  assign opnd_a    = fwd_select(i_fwd_a, i_read_data1, i_mem_fwd_data, i_wb_fwd_data);
  assign opnd_b    = fwd_select(i_fwd_b, i_read_data2, i_mem_fwd_data, i_wb_fwd_data);
  assign alu_b     = alu_src ? i_sign_ext_imm : opnd_b;
  assign branch_pc = i_pc_plus4 + (i_sign_ext_imm << 2);
  assign write_reg = reg_dst ? i_rd : i_rt;

  // Single-cycle ALU; MUL results come from the sequencer instead.
  always_comb begin
    alu_result = opnd_a + alu_b;
    case (alu_op)
      ALU_ADD: alu_result = opnd_a + alu_b;
      ALU_SUB: alu_result = opnd_a - alu_b;
      ALU_AND: alu_result = opnd_a & alu_b;
      ALU_OR:  alu_result = opnd_a | alu_b;
      ALU_NOR: alu_result = ~(opnd_a | alu_b);
      ALU_SLT: alu_result = {31'd0, $signed(opnd_a) < $signed(alu_b)};
      default: alu_result = opnd_a + alu_b;
    endcase
  end

  ex_mul_iter u_mul (
    .clk     (i_clk),
    .rst     (i_rst),
    .flush   (i_flush),
    .start   (is_mul && !i_flush),
    .a       (opnd_a),
    .b       (opnd_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Stall while a multiply is being started or is iterating; never during reset.
  always_comb begin
    o_stall = 1'b0;
    if (!i_rst) begin
      o_stall = mul_busy || (!mul_busy && !mul_done && is_mul && !i_flush);
    end
  end

  // EX/MEM register: flush and stall insert bubbles, DONE commits the product.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_branch_pc   <= '0;
      o_result      <= '0;
      o_read_data2  <= '0;
      o_zero        <= 1'b0;
      o_write_reg   <= '0;
      o_WB_control  <= '0;
      o_MEM_control <= '0;
    end else if (i_flush || o_stall) begin
      o_WB_control  <= '0;
      o_MEM_control <= '0;
    end else begin
      o_branch_pc   <= branch_pc;
      o_read_data2  <= opnd_b;
      o_write_reg   <= write_reg;
      o_WB_control  <= i_WB_control;
      o_MEM_control <= i_MEM_control;
      if (mul_done) begin
        o_result <= mul_product;
        o_zero   <= (mul_product == 32'd0);
      end else begin
        o_result <= alu_result;
        o_zero   <= (alu_result == 32'd0);
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized ALU
// traffic compared against a behavioural model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_plus4, read_data1, read_data2, sign_ext_imm, mem_fwd_data, wb_fwd_data;
  logic [4:0]  rt, rd;
  logic [3:0]  ex_control;
  logic [2:0]  mem_control;
  logic [1:0]  wb_control, fwd_a, fwd_b;
  logic        flush;
  logic [31:0] branch_pc, result, rd2_out;
  logic        zero, stall;
  logic [4:0]  write_reg;
  logic [1:0]  wb_out;
  logic [2:0]  mem_out;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .i_clk(clk), .i_rst(rst), .i_pc_plus4(pc_plus4), .i_read_data1(read_data1),
    .i_read_data2(read_data2), .i_sign_ext_imm(sign_ext_imm), .i_rt(rt), .i_rd(rd),
    .i_EX_control(ex_control), .i_MEM_control(mem_control), .i_WB_control(wb_control),
    .i_fwd_a(fwd_a), .i_fwd_b(fwd_b), .i_mem_fwd_data(mem_fwd_data),
    .i_wb_fwd_data(wb_fwd_data), .i_flush(flush), .o_branch_pc(branch_pc),
    .o_result(result), .o_read_data2(rd2_out), .o_zero(zero), .o_write_reg(write_reg),
    .o_WB_control(wb_out), .o_MEM_control(mem_out), .o_stall(stall)
  );

  // Behavioural model of the forwarding choice.
  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] r,
                                          input logic [31:0] m, input logic [31:0] w);
    if (sel == 2'b10) return m;
    if (sel == 2'b01) return w;
    return r;
  endfunction

  // Behavioural model of the single-cycle ALU.
  function automatic logic [31:0] ref_alu(input logic [1:0] aluop, input logic [5:0] funct,
                                          input logic [31:0] a, input logic [31:0] b);
    if (aluop == 2'b00) return a + b;
    if (aluop == 2'b01) return a - b;
    if (aluop == 2'b11) return a | b;
    case (funct)
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h27:   return ~(a | b);
      6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  task automatic applyStimulus(input logic [3:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                               input logic [1:0] fa, input logic [1:0] fb,
                               input logic [31:0] mfwd, input logic [31:0] wfwd);
    ex_control   = ex;
    mem_control  = mem;
    wb_control   = wb;
    read_data1   = a;
    read_data2   = b;
    sign_ext_imm = imm;
    fwd_a        = fa;
    fwd_b        = fb;
    mem_fwd_data = mfwd;
    wb_fwd_data  = wfwd;
    rt           = 5'd3;
    rd           = 5'd9;
    pc_plus4     = 32'h100;
    flush        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(4'b1010, 3'b111, 2'b11, 32'd7, 32'd5, 32'h20, 2'b00, 2'b00, 0, 0);
    rst = 1'b1;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall got %0b want 0", stall); end
    tick(); tick();
    tests_run++;
    if ({result, branch_pc, rd2_out, zero, write_reg, wb_out, mem_out} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs result=%h bpc=%h rd2=%h wr=%0d wb=%b mem=%b want all 0",
               result, branch_pc, rd2_out, write_reg, wb_out, mem_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    applyStimulus(4'b1010, 3'b000, 2'b10, 32'd7, 32'd5, 32'h20, 2'b00, 2'b00, 32'd99, 32'd77);
    tick();
    tests_run++;
    if (result !== 32'd12 || zero !== 1'b0 || write_reg !== 5'd9 || wb_out !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL add got res=%0d z=%0b wr=%0d wb=%b want 12 0 9 10", result, zero, write_reg, wb_out);
    end
  endtask

  task automatic test_sub_branch();
    applyStimulus(4'b0001, 3'b001, 2'b00, 32'd123, 32'd5, 32'd4, 2'b10, 2'b00, 32'd5, 32'd0);
    tick();
    tests_run++;
    if (zero !== 1'b1 || branch_pc !== 32'h110 || mem_out[0] !== 1'b1 || write_reg !== 5'd3) begin
      tests_failed++;
      $display("[TB] FAIL sub_branch got z=%0b bpc=%h br=%0b wr=%0d want 1 110 1 3",
               zero, branch_pc, mem_out[0], write_reg);
    end
  endtask

  task automatic test_slt_overflow();
    applyStimulus(4'b1010, 3'b000, 2'b01, 32'h8000_0000, 32'd1, 32'h2A, 2'b00, 2'b00, 0, 0);
    tick();
    tests_run++;
    if (result !== 32'd1) begin tests_failed++; $display("[TB] FAIL slt got %h want 1", result); end
    applyStimulus(4'b1010, 3'b000, 2'b01, 32'h7FFF_FFFF, 32'd1, 32'h20, 2'b00, 2'b00, 0, 0);
    tick();
    tests_run++;
    if (result !== 32'h8000_0000 || wb_out !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL add_wrap got %h wb=%b want 80000000 01", result, wb_out);
    end
  endtask

  task automatic test_random_alu();
    logic [5:0]  functs [7];
    logic [31:0] a, b, imm, m, w, tmp, fa_v, fb_v, alu_b, exp_res;
    logic [3:0]  ex;
    logic [2:0]  mem;
    logic [1:0]  wb, fa, fb;
    logic [5:0]  funct;
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom; m = $urandom; w = $urandom; tmp = $urandom;
      if (i % 8 == 0) b = a;
      funct = functs[$urandom_range(0, 6)];
      if (funct == 6'h00) funct = 6'($urandom_range(0, 63));
      if (funct == 6'h18) funct = 6'h20;
      imm = {tmp[31:6], funct};
      ex  = 4'($urandom_range(0, 15));
      mem = 3'($urandom_range(0, 7));
      wb  = 2'($urandom_range(0, 3));
      fa  = 2'($urandom_range(0, 3));
      fb  = 2'($urandom_range(0, 3));
      applyStimulus(ex, mem, wb, a, b, imm, fa, fb, m, w);
      rt = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      pc_plus4 = $urandom;
      fa_v  = ref_fwd(fa, a, m, w);
      fb_v  = ref_fwd(fb, b, m, w);
      alu_b = ex[2] ? imm : fb_v;
      exp_res = ref_alu(ex[1:0], funct, fa_v, alu_b);
      #1;
      tests_run++;
      if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL rand_stall[%0d] got 1 want 0", i); end
      tick();
      tests_run++;
      if (result !== exp_res || zero !== (exp_res == 32'd0) || rd2_out !== fb_v ||
          branch_pc !== pc_plus4 + imm * 4 || write_reg !== (ex[3] ? rd : rt) ||
          wb_out !== wb || mem_out !== mem) begin
        tests_failed++;
        $display("[TB] FAIL rand_alu[%0d] ex=%b f=%h got res=%h z=%0b rd2=%h bpc=%h wr=%0d wb=%b mem=%b want res=%h rd2=%h",
                 i, ex, funct, result, zero, rd2_out, branch_pc, write_reg, wb_out, mem_out, exp_res, fb_v);
      end
    end
  endtask

  task automatic test_mul(input logic [31:0] a, input logic [31:0] b);
    int stalls;
    logic [31:0] exp_prod;
    exp_prod = a * b;
    applyStimulus(4'b1010, 3'b010, 2'b10, a, b, 32'h18, 2'b00, 2'b00, 32'h0, 32'h0);
    #1;
    stalls = stall ? 1 : 0;
    for (int i = 0; i < 40 && stall; i++) begin
      tick();
      tests_run++;
      if (wb_out !== 2'b00 || mem_out !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL mul_bubble got wb=%b mem=%b want 00 000", wb_out, mem_out);
      end
      if (stall) stalls++;
    end
    tests_run++;
    if (stalls !== 33) begin tests_failed++; $display("[TB] FAIL mul_stall_count got %0d want 33", stalls); end
    tick();
    applyStimulus(4'b0000, 3'b000, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    #1;
    tests_run++;
    if (result !== exp_prod || zero !== (exp_prod == 32'd0) || wb_out !== 2'b10 ||
        mem_out !== 3'b010 || write_reg !== 5'd9 || stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mul_commit got res=%h wb=%b mem=%b wr=%0d st=%0b want res=%h 10 010 9 0",
               result, wb_out, mem_out, write_reg, stall, exp_prod);
    end
  endtask

  task automatic test_flush_busy();
    applyStimulus(4'b1010, 3'b010, 2'b11, 32'd5, 32'd6, 32'h18, 2'b00, 2'b00, 0, 0);
    repeat (11) tick();
    tests_run++;
    if (stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_busy_stall got 0 want 1"); end
    flush = 1'b1;
    tick();
    tests_run++;
    if (wb_out !== 2'b00 || mem_out !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL flush_bubble got wb=%b mem=%b want 00 000", wb_out, mem_out);
    end
    applyStimulus(4'b1010, 3'b000, 2'b01, 32'd3, 32'd4, 32'h20, 2'b00, 2'b00, 0, 0);
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_idle_stall got 1 want 0"); end
    tick();
    tests_run++;
    if (result !== 32'd7 || wb_out !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL flush_next got res=%0d wb=%b want 7 01", result, wb_out);
    end
  endtask

  task automatic test_flush_mul_start();
    applyStimulus(4'b1010, 3'b010, 2'b11, 32'd5, 32'd6, 32'h18, 2'b00, 2'b00, 0, 0);
    flush = 1'b1;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_start_stall got 1 want 0"); end
    tick();
    tests_run++;
    if (wb_out !== 2'b00 || mem_out !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL flush_start_bubble got wb=%b mem=%b want 00 000", wb_out, mem_out);
    end
    applyStimulus(4'b1010, 3'b000, 2'b01, 32'd8, 32'd2, 32'h22, 2'b00, 2'b00, 0, 0);
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_start_idle got 1 want 0"); end
    tick();
    tests_run++;
    if (result !== 32'd6) begin tests_failed++; $display("[TB] FAIL flush_start_next got %0d want 6", result); end
  endtask

  task automatic test_reset_mid_mul();
    applyStimulus(4'b1010, 3'b010, 2'b11, 32'd5, 32'd6, 32'h18, 2'b00, 2'b00, 0, 0);
    repeat (21) tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mul_stall got 1 want 0"); end
    tick();
    tests_run++;
    if ({result, branch_pc, rd2_out, zero, write_reg, wb_out, mem_out} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mul_outputs result=%h wr=%0d wb=%b mem=%b want all 0", result, write_reg, wb_out, mem_out);
    end
    rst = 1'b0;
    applyStimulus(4'b1010, 3'b000, 2'b10, 32'd1, 32'd1, 32'h20, 2'b00, 2'b00, 0, 0);
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mul_idle got 1 want 0"); end
    tick();
    tests_run++;
    if (result !== 32'd2 || wb_out !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL rst_mul_add got res=%0d wb=%b want 2 10", result, wb_out);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_branch();
    test_slt_overflow();
    test_random_alu();
    test_mul(32'hFFFF_FFFF, 32'd3);
    test_mul($urandom, $urandom);
    test_flush_busy();
    test_flush_mul_start();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be (name  direction  width  meaning): i_clk  in  1  clock; i_rst  in  1  synchronous active-high reset.
REQ-003 i_pc_plus4  in  32  PC+4 from ID/EX; i_read_data1, i_read_data2  in  32  register operands A and B.
REQ-004 i_sign_ext_imm  in  32  sign-extended immediate (bits [5:0] = funct); i_rt, i_rd  in  5  destination candidates.
REQ-005 i_EX_control  in  4  {RegDst, ALUSrc, ALUOp[1:0]}; i_MEM_control  in  3  {MemWrite, MemRead, Branch}; i_WB_control  in  2  pass-through.
REQ-006 i_fwd_a, i_fwd_b  in  2  forward select (00 register, 10 i_mem_fwd_data, 01 i_wb_fwd_data, 11 register); i_mem_fwd_data, i_wb_fwd_data  in  32.
REQ-007 i_flush  in  1  taken branch, squash in-flight EX work.
REQ-008 o_branch_pc, o_result, o_read_data2  out  32; o_zero  out  1; o_write_reg  out  5; o_WB_control  out  2; o_MEM_control  out  3; all registered (EX/MEM register).
REQ-009 o_stall  out  1  combinational; high freezes PC, IF/ID and ID/EX.

Function
REQ-010 Operand A/B SHALL be selected by i_fwd_a/i_fwd_b per REQ-006; ALU B input SHALL be i_sign_ext_imm when ALUSrc=1, else forwarded B.
REQ-011 ALU control: ALUOp 00 ADD, 01 SUB, 11 OR; ALUOp 10 decodes funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT (signed), 0x18 MUL; other funct SHALL yield ADD.
REQ-012 ADD/SUB SHALL wrap modulo 2^32 with no overflow trap; SLT SHALL produce 32'd1 or 32'd0.
REQ-013 Non-MUL instructions SHALL have 1-cycle latency: result, o_zero (result==0), branch PC (i_pc_plus4 + (imm<<2), mod 2^32), forwarded B, write reg (RegDst ? rd : rt) and controls registered at the next edge.
REQ-014 MUL SHALL return low 32 bits of the unsigned-equivalent product (identical to signed low half) via a 32-iteration shift-add sequencer.
REQ-015 FSM states IDLE, BUSY, DONE; IDLE->BUSY when decoded MUL and i_flush=0, latching forwarded A/B, counter=0; BUSY->DONE after 32nd iteration (counter=31); DONE->IDLE unconditionally.
REQ-016 o_stall SHALL be high in IDLE when MUL is decoded (and i_flush=0) and in all BUSY cycles; low in DONE: 33 stall cycles per MUL.
REQ-017 While o_stall is high the EX/MEM register SHALL load a bubble (o_WB_control=0, o_MEM_control=0, data don't-care-held).
REQ-018 In DONE the EX/MEM register SHALL load the product with the held instruction's controls and write reg; the MUL SHALL not restart.
REQ-019 i_flush=1 SHALL load a bubble at the next edge and force FSM to IDLE from any state; flush beats MUL start and DONE commit.
REQ-020 Forward values arriving during BUSY SHALL be ignored (operands already latched).

Reset
REQ-021 With i_rst=1 at an edge all outputs registers SHALL clear to 0, FSM to IDLE, counter and operand/product registers to 0; o_stall SHALL be 0 while i_rst is high.
REQ-022 Reset mid-MUL SHALL abandon the operation with no result committed.

Structure
REQ-023 A shared package SHALL hold ALUOp codes, funct constants, internal ALU op enumeration, forward-select encodings and FSM state encoding.
REQ-024 The sequencer SHALL be sub-module ex_mul_iter (start, operands, busy, done, product); ALU, muxes and EX/MEM register stay in ex_stage.

Verification
REQ-025 ADD R-type A=7, B=5, fwd 00 -> next edge o_result=12, o_zero=0, o_write_reg=rd.
REQ-026 SUB A=5, B=5 with i_fwd_a=10, i_mem_fwd_data=5, Branch=1, pc_plus4=0x100, imm=4 -> o_zero=1, o_branch_pc=0x110, o_MEM_control[0]=1.
REQ-027 MUL A=0xFFFFFFFF (-1), B=3 -> o_stall high 33 cycles, bubbles output, then o_result=0xFFFFFFFD with held controls, o_stall low.
REQ-028 i_flush asserted at BUSY counter=10 -> bubble next edge, FSM IDLE, no product committed; same-cycle flush+MUL -> no stall.
REQ-029 i_rst at BUSY counter=20 -> all outputs 0, o_stall 0; following ADD 1+1 -> o_result=2 after one cycle.
REQ-030 SLT A=0x80000000, B=1 -> o_result=1; ADD 0x7FFFFFFF+1 -> 0x80000000, no trap.
